// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encoding and default limits.
package mem_bus_pkg;

  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_STARVE_LIMIT = 8;
  localparam int CNT_W            = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc loads 1.
module arb_sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for the shared data-memory bus: CPU priority, bounded DMA bursts,
// DMA anti-starvation. Define ARB_PERF_CNT_EN to add stall/beat performance counters.
//
// state    | meaning
// ARB_IDLE | no owner; CPU wins unless the DMA is starved
// ARB_CPU  | CPU granted last cycle; same decision rules as idle
// ARB_DMA  | DMA owns the bus until last beat, burst limit or request drop
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_wait,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       cpu_stall_cycles,
  output logic [31:0]       dma_beats,
`endif
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, starve_cnt, beats_prev;
  logic             starved, burst_end;

  arb_sat_counter #(.W(CNT_W), .MAX(MAX_BURST)) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state != ARB_DMA),
    .inc   (dma_gnt),
    .cnt   (burst_cnt)
  );

  arb_sat_counter #(.W(CNT_W), .MAX(STARVE_LIMIT)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (dma_gnt | ~dma_req),
    .inc   (dma_req & ~dma_gnt),
    .cnt   (starve_cnt)
  );

  // The entry beat is granted from IDLE/CPU, so it counts as beat one of the burst.
  assign beats_prev = (state == ARB_DMA) ? burst_cnt : '0;
  assign starved    = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign burst_end  = dma_last || (beats_prev == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    if (reset) begin
      state_nxt = ARB_IDLE;
    end else begin
      case (state)
        ARB_DMA: begin
          if (dma_req) begin
            dma_gnt   = 1'b1;
            state_nxt = burst_end ? ARB_IDLE : ARB_DMA;
          end else if (cpu_req) begin
            cpu_gnt   = 1'b1;
            state_nxt = ARB_CPU;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end
        default: begin
          if (dma_req && starved) begin
            dma_gnt   = 1'b1;
            state_nxt = burst_end ? ARB_IDLE : ARB_DMA;
          end else if (cpu_req) begin
            cpu_gnt   = 1'b1;
            state_nxt = ARB_CPU;
          end else if (dma_req) begin
            dma_gnt   = 1'b1;
            state_nxt = burst_end ? ARB_IDLE : ARB_DMA;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_rd    = ~cpu_wr;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_rd    = ~dma_wr;
      mem_wr    = dma_wr;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign cpu_wait = cpu_req & ~cpu_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_wr;
      dma_rvalid <= dma_gnt & ~dma_wr;
      if (cpu_gnt && !cpu_wr) cpu_rdata <= mem_rdata;
      if (dma_gnt && !dma_wr) dma_rdata <= mem_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_stall_cycles <= '0;
      dma_beats        <= '0;
    end else begin
      if (cpu_wait) cpu_stall_cycles <= cpu_stall_cycles + 32'd1;
      if (dma_gnt)  dma_beats        <= dma_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed stimulus pushes expected bus/read
// records tagged with their cycle; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wr, dma_req, dma_wr, dma_last;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_gnt, cpu_wait, cpu_rvalid, dma_gnt, dma_rvalid, mem_rd, mem_wr;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] cpu_stall_cycles, dma_beats;
`endif

  mem_bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_wait   (cpu_wait),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_wr     (dma_wr),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_last   (dma_last),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
`ifdef ARB_PERF_CNT_EN
    .cpu_stall_cycles (cpu_stall_cycles),
    .dma_beats        (dma_beats),
`endif
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        cg, dg, rd, wr, wt;
    logic [31:0] addr, wdata;
  } bus_exp_t;

  typedef struct {
    int          cyc;
    logic        cv, dv;
    logic [31:0] cd, dd;
  } rd_exp_t;

  bus_exp_t    bus_q[$];
  rd_exp_t     rd_q[$];
  logic [31:0] m_cpu_rd = '0;
  logic [31:0] m_dma_rd = '0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0; dma_last = 0;
    mem_rdata = '0;
  endtask

  task automatic exp_cpu(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata);
    bus_exp_t b;
    rd_exp_t  r;
    b = '{cyc, 1'b1, 1'b0, ~wr, wr, 1'b0, addr, wdata};
    bus_q.push_back(b);
    if (!wr) begin
      m_cpu_rd = rdata;
      r = '{cyc + 1, 1'b1, 1'b0, m_cpu_rd, m_dma_rd};
      rd_q.push_back(r);
    end
  endtask

  task automatic exp_dma(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic wt);
    bus_exp_t b;
    rd_exp_t  r;
    b = '{cyc, 1'b0, 1'b1, ~wr, wr, wt, addr, wdata};
    bus_q.push_back(b);
    if (!wr) begin
      m_dma_rd = rdata;
      r = '{cyc + 1, 1'b0, 1'b1, m_cpu_rd, m_dma_rd};
      rd_q.push_back(r);
    end
  endtask

  task automatic exp_idle(input logic wt);
    bus_exp_t b;
    b = '{cyc, 1'b0, 1'b0, 1'b0, 1'b0, wt, 32'h0, 32'h0};
    bus_q.push_back(b);
  endtask

  task automatic exp_rd_state();
    rd_exp_t r;
    r = '{cyc, 1'b0, 1'b0, m_cpu_rd, m_dma_rd};
    rd_q.push_back(r);
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic chk_perf(input logic [31:0] es, input logic [31:0] eb);
    @(negedge clk);
    #1;
    compared++;
    if (cpu_stall_cycles !== es || dma_beats !== eb) begin
      mismatched++;
      $display("FAIL perf cyc=%0d got stall=%0d beats=%0d expected stall=%0d beats=%0d",
               cyc, cpu_stall_cycles, dma_beats, es, eb);
    end
  endtask
`endif

  // Monitor: compare whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    bus_exp_t b;
    rd_exp_t  r;
    while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
      b = bus_q.pop_front();
      compared++; mismatched++;
      $display("FAIL bus_missed expected cycle %0d not checked", b.cyc);
    end
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
      r = rd_q.pop_front();
      compared++; mismatched++;
      $display("FAIL rd_missed expected cycle %0d not checked", r.cyc);
    end
    if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
      b = bus_q.pop_front();
      compared++;
      if ({cpu_gnt, dma_gnt, mem_rd, mem_wr, cpu_wait, mem_addr, mem_wdata} !==
          {b.cg, b.dg, b.rd, b.wr, b.wt, b.addr, b.wdata}) begin
        mismatched++;
        $display("FAIL bus cyc=%0d got cg=%b dg=%b rd=%b wr=%b wait=%b addr=%h wdata=%h expected cg=%b dg=%b rd=%b wr=%b wait=%b addr=%h wdata=%h",
                 cyc, cpu_gnt, dma_gnt, mem_rd, mem_wr, cpu_wait, mem_addr, mem_wdata,
                 b.cg, b.dg, b.rd, b.wr, b.wt, b.addr, b.wdata);
      end
    end else if (cpu_gnt || dma_gnt || mem_rd || mem_wr) begin
      compared++; mismatched++;
      $display("FAIL bus_unexpected cyc=%0d got cg=%b dg=%b rd=%b wr=%b expected no grant",
               cyc, cpu_gnt, dma_gnt, mem_rd, mem_wr);
    end
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      r = rd_q.pop_front();
      compared++;
      if ({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata} !== {r.cv, r.dv, r.cd, r.dd}) begin
        mismatched++;
        $display("FAIL rdata cyc=%0d got cv=%b dv=%b cd=%h dd=%h expected cv=%b dv=%b cd=%h dd=%h",
                 cyc, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata, r.cv, r.dv, r.cd, r.dd);
      end
    end else if (cpu_rvalid === 1'b1 || dma_rvalid === 1'b1) begin
      compared++; mismatched++;
      $display("FAIL rvalid_unexpected cyc=%0d got cv=%b dv=%b expected 0 0",
               cyc, cpu_rvalid, dma_rvalid);
    end
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick(); tick();

    // Reset dominates requests; registers already cleared.
    cpu_req = 1; dma_req = 1; cpu_addr = 32'h10; dma_addr = 32'h20;
    exp_idle(1'b1);
    exp_rd_state();
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();

    // CPU-only reads then a write.
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10; cpu_wdata = 32'h55; mem_rdata = 32'hDEADBEEF;
    exp_cpu(1'b0, 32'h10, 32'h55, 32'hDEADBEEF);
    tick();
    cpu_addr = 32'h14; mem_rdata = 32'h12345678;
    exp_cpu(1'b0, 32'h14, 32'h55, 32'h12345678);
    tick();
    cpu_wr = 1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A5A5A5; mem_rdata = 32'hFFFF0000;
    exp_cpu(1'b1, 32'h20, 32'hA5A5A5A5, 32'h0);
    tick();
    idle_inputs();
    tick();

    // Simultaneous requests: CPU wins 8 times, then the starved DMA is forced in.
    dma_req = 1; dma_wr = 0; dma_addr = 32'h200; cpu_req = 1; cpu_wr = 0;
    for (int i = 0; i < 8; i++) begin
      cpu_addr = 32'h100 + 32'(4 * i);
      mem_rdata = 32'h1000 + 32'(i);
      exp_cpu(1'b0, cpu_addr, 32'h0, mem_rdata);
      tick();
    end
    dma_last = 1; mem_rdata = 32'hCAFEF00D;
    exp_dma(1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 1'b1);
    tick();
    dma_req = 0; dma_last = 0; cpu_addr = 32'h180; mem_rdata = 32'h2222;
    exp_cpu(1'b0, 32'h180, 32'h0, 32'h2222);
    tick();
    idle_inputs();
    tick();

    // Four-beat DMA write burst ended by dma_last; CPU waits then goes next.
    for (int i = 0; i < 4; i++) begin
      dma_req = 1; dma_wr = 1; dma_addr = 32'(4 * i); dma_wdata = 32'hD0 + 32'(i);
      dma_last = (i == 3);
      cpu_req = (i > 0); cpu_wr = 0; cpu_addr = 32'h40;
      exp_dma(1'b1, dma_addr, dma_wdata, 32'h0, i > 0);
      tick();
    end
    dma_last = 0; dma_addr = 32'h1000; dma_wdata = 32'h0; mem_rdata = 32'h4444;
    exp_cpu(1'b0, 32'h40, 32'h0, 32'h4444);
    tick();

    // DMA without dma_last: exactly 16 beats, one CPU access, then DMA resumes.
    for (int k = 0; k < 16; k++) begin
      dma_addr = 32'h1000 + 32'(4 * k); dma_wdata = 32'(k);
      cpu_req = (k > 0); cpu_addr = 32'h44;
      exp_dma(1'b1, dma_addr, dma_wdata, 32'h0, k > 0);
      tick();
    end
    dma_addr = 32'h1040; dma_wdata = 32'd16; mem_rdata = 32'h5555;
    exp_cpu(1'b0, 32'h44, 32'h0, 32'h5555);
    tick();
    cpu_req = 0;
    exp_dma(1'b1, 32'h1040, 32'd16, 32'h0, 1'b0);
    tick();
    idle_inputs();
    tick();

    // Reset in the middle of a DMA burst.
    for (int k = 0; k < 3; k++) begin
      dma_req = 1; dma_wr = 1; dma_addr = 32'h300 + 32'(4 * k); dma_wdata = 32'hB0 + 32'(k);
      cpu_req = (k > 0); cpu_wr = 0; cpu_addr = 32'h80;
      exp_dma(1'b1, dma_addr, dma_wdata, 32'h0, k > 0);
      tick();
    end
    reset = 1; dma_addr = 32'h30C; dma_wdata = 32'hB3;
    exp_idle(1'b1);
    tick();
    reset = 0;
    m_cpu_rd = '0; m_dma_rd = '0;
    exp_rd_state();
    mem_rdata = 32'h77;
    exp_cpu(1'b0, 32'h80, 32'h0, 32'h77);
`ifdef ARB_PERF_CNT_EN
    chk_perf(32'd0, 32'd0);
`endif
    tick();
    cpu_req = 0;
    exp_dma(1'b1, 32'h30C, 32'hB3, 32'h0, 1'b0);
    tick();
    cpu_req = 1; cpu_addr = 32'h84; dma_addr = 32'h310; dma_wdata = 32'hB4;
    exp_dma(1'b1, 32'h310, 32'hB4, 32'h0, 1'b1);
    tick();
    dma_last = 1; dma_addr = 32'h314; dma_wdata = 32'hB5;
    exp_dma(1'b1, 32'h314, 32'hB5, 32'h0, 1'b1);
    tick();
    dma_req = 0; dma_last = 0; mem_rdata = 32'h88;
    exp_cpu(1'b0, 32'h84, 32'h0, 32'h88);
    tick();
    idle_inputs();
`ifdef ARB_PERF_CNT_EN
    chk_perf(32'd2, 32'd3);
`endif
    tick(); tick(); tick();

    while (bus_q.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL bus_leftover expected cycle %0d never seen", bus_q[0].cyc);
      void'(bus_q.pop_front());
    end
    while (rd_q.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL rd_leftover expected cycle %0d never seen", rd_q[0].cyc);
      void'(rd_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
